// File: rtl/qoa_slice_sequencer.sv
// Sequences the QOA decoder core one 64-bit slice at a time and buffers decoded samples.
// Optional LMS state loading is compiled in when QOA_LMS_LOAD_EN is defined.
//
// state       | meaning
// COLLECT     | accept slice (or LMS) bytes, in_ready high
// RESID       | wait for FIFO room, then pulse the sample command
// WAIT        | idle DEC_LATENCY cycles while the core decodes
// TXCMD       | pulse 0x80 to request the sample
// GAP_HI      | capture sample high byte from dec_rx
// TXLO        | pulse 0x00 for the low byte
// GAP_LO      | capture sample low byte from dec_rx
// TXEND       | pulse 0x00 to return the core to its wait state
// PUSH        | write sample to FIFO, advance residual index
// LCMD..LGAP2 | LMS entry burst: select, high, low pulses each with a gap
module qoa_slice_sequencer #(
    parameter int DEC_LATENCY = 80,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_lms,
    output logic [7:0]  dec_byte,
    output logic        dec_rdy,
    input  logic [7:0]  dec_rx,
    output logic [15:0] out_sample,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic        slice_done
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int WW = (DEC_LATENCY > 1) ? $clog2(DEC_LATENCY + 1) : 1;
    localparam logic [CW-1:0] FIFO_FULL = CW'(FIFO_DEPTH);
    localparam logic [WW-1:0] WAIT_LOAD = WW'(DEC_LATENCY);

    typedef enum logic [3:0] {
        S_COLLECT,
        S_RESID,
        S_WAIT,
        S_TXCMD,
        S_GAP_HI,
        S_TXLO,
        S_GAP_LO,
        S_TXEND,
        S_PUSH,
        S_LCMD,
        S_LGAP0,
        S_LHI,
        S_LGAP1,
        S_LLO,
        S_LGAP2
    } state_t;

    state_t         state_q, state_d;
    logic [63:0]    slice_q, slice_d;
    logic [3:0]     byte_cnt_q, byte_cnt_d;
    logic [4:0]     idx_q, idx_d;
    logic [WW-1:0]  wait_q, wait_d;
    logic [7:0]     hi_q, hi_d;
    logic [7:0]     lo_q, lo_d;
    logic           slice_done_q, slice_done_d;
    logic           fifo_push;
    logic           fifo_pop;
    logic [2:0]     resid;

    logic [15:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0]  wptr_q, rptr_q;
    logic [CW-1:0]  count_q;

`ifdef QOA_LMS_LOAD_EN
    logic           lms_q, lms_d;
    logic [2:0]     lms_k_q, lms_k_d;
`else
    logic           unused_lms;
    assign unused_lms = in_lms;
`endif

    // Residual i sits at slice[59-3i -: 3]; shift it down to bit 0.
    assign resid = 3'(slice_q >> (7'd57 - 7'(3 * idx_q)));

    always_comb begin
        state_d      = state_q;
        slice_d      = slice_q;
        byte_cnt_d   = byte_cnt_q;
        idx_d        = idx_q;
        wait_d       = wait_q;
        hi_d         = hi_q;
        lo_d         = lo_q;
        slice_done_d = 1'b0;
        fifo_push    = 1'b0;
        in_ready     = 1'b0;
        dec_rdy      = 1'b0;
        dec_byte     = 8'h00;
`ifdef QOA_LMS_LOAD_EN
        lms_d        = lms_q;
        lms_k_d      = lms_k_q;
`endif
        case (state_q)
            S_COLLECT: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    slice_d    = {slice_q[55:0], in_data};
                    byte_cnt_d = byte_cnt_q + 4'd1;
`ifdef QOA_LMS_LOAD_EN
                    if (lms_q || (in_lms && byte_cnt_q == 4'd0)) begin
                        lms_d = 1'b1;
                        if (byte_cnt_q[0]) state_d = S_LCMD;
                    end else if (byte_cnt_q == 4'd7) begin
                        state_d = S_RESID;
                        idx_d   = 5'd0;
                    end
`else
                    if (byte_cnt_q == 4'd7) begin
                        state_d = S_RESID;
                        idx_d   = 5'd0;
                    end
`endif
                end
            end
            S_RESID: begin
                if (count_q != FIFO_FULL) begin
                    dec_rdy  = 1'b1;
                    dec_byte = {slice_q[63:60], resid, 1'b1};
                    wait_d   = WAIT_LOAD;
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                wait_d = wait_q - WW'(1);
                if (wait_q == WW'(1)) state_d = S_TXCMD;
            end
            S_TXCMD: begin
                dec_rdy  = 1'b1;
                dec_byte = 8'h80;
                state_d  = S_GAP_HI;
            end
            S_GAP_HI: begin
                hi_d    = dec_rx;
                state_d = S_TXLO;
            end
            S_TXLO: begin
                dec_rdy = 1'b1;
                state_d = S_GAP_LO;
            end
            S_GAP_LO: begin
                lo_d    = dec_rx;
                state_d = S_TXEND;
            end
            S_TXEND: begin
                dec_rdy = 1'b1;
                state_d = S_PUSH;
            end
            S_PUSH: begin
                fifo_push = 1'b1;
                if (idx_q == 5'd19) begin
                    idx_d        = 5'd0;
                    slice_done_d = 1'b1;
                    byte_cnt_d   = 4'd0;
                    state_d      = S_COLLECT;
                end else begin
                    idx_d   = idx_q + 5'd1;
                    state_d = S_RESID;
                end
            end
`ifdef QOA_LMS_LOAD_EN
            S_LCMD: begin
                dec_rdy  = 1'b1;
                dec_byte = {4'b0000, lms_k_q[1:0], lms_k_q[2], 1'b0};
                state_d  = S_LGAP0;
            end
            S_LGAP0: state_d = S_LHI;
            S_LHI: begin
                dec_rdy  = 1'b1;
                dec_byte = slice_q[15:8];
                state_d  = S_LGAP1;
            end
            S_LGAP1: state_d = S_LLO;
            S_LLO: begin
                dec_rdy  = 1'b1;
                dec_byte = slice_q[7:0];
                state_d  = S_LGAP2;
            end
            S_LGAP2: begin
                lms_k_d = lms_k_q + 3'd1;
                state_d = S_COLLECT;
                if (lms_k_q == 3'd7) begin
                    lms_d      = 1'b0;
                    byte_cnt_d = 4'd0;
                end
            end
`endif
            default: state_d = S_COLLECT;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q      <= S_COLLECT;
            slice_q      <= '0;
            byte_cnt_q   <= '0;
            idx_q        <= '0;
            wait_q       <= '0;
            hi_q         <= '0;
            lo_q         <= '0;
            slice_done_q <= 1'b0;
`ifdef QOA_LMS_LOAD_EN
            lms_q        <= 1'b0;
            lms_k_q      <= '0;
`endif
        end else begin
            state_q      <= state_d;
            slice_q      <= slice_d;
            byte_cnt_q   <= byte_cnt_d;
            idx_q        <= idx_d;
            wait_q       <= wait_d;
            hi_q         <= hi_d;
            lo_q         <= lo_d;
            slice_done_q <= slice_done_d;
`ifdef QOA_LMS_LOAD_EN
            lms_q        <= lms_d;
            lms_k_q      <= lms_k_d;
`endif
        end
    end

    // Push only happens after RESID saw free space, so push+pop never meet a full FIFO.
    assign out_valid = (count_q != '0);
    assign fifo_pop  = out_valid && out_ready;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (fifo_push) begin
                mem_q[wptr_q] <= {hi_q, lo_q};
                wptr_q        <= wptr_q + AW'(1);
            end
            if (fifo_pop) rptr_q <= rptr_q + AW'(1);
            case ({fifo_push, fifo_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign out_sample = mem_q[rptr_q];
    assign busy       = (state_q != S_COLLECT) || (byte_cnt_q != 4'd0);
    assign slice_done = slice_done_q;

endmodule

// File: tb/tb_qoa_slice_sequencer.sv
// Directed bench for qoa_slice_sequencer with a scripted decoder-core stub and scoreboard queues.
module tb_qoa_slice_sequencer;
    localparam int DL = 80;
    localparam int FD = 4;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        in_lms;
    logic [7:0]  dec_byte;
    logic        dec_rdy;
    logic [7:0]  dec_rx;
    logic [15:0] out_sample;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        slice_done;

    qoa_slice_sequencer #(.DEC_LATENCY(DL), .FIFO_DEPTH(FD)) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_lms     (in_lms),
        .dec_byte   (dec_byte),
        .dec_rdy    (dec_rdy),
        .dec_rx     (dec_rx),
        .out_sample (out_sample),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .slice_done (slice_done)
    );

    initial forever #5 sys_clk = ~sys_clk;

    int n_cmp = 0;
    int n_err = 0;
    int n_done = 0;
    int n_pop = 0;
    int n_scmd = 0;
    int cyc = 0;
    int last_cmd_cyc = 0;
    int mon_phase = 0;
    logic prev_rdy = 1'b0;
    logic [7:0]  e_cmd;
    logic [15:0] e_smp;
    logic [7:0]  exp_cmd_q [$];
    logic [15:0] exp_smp_q [$];

    // Core stub: hi/lo either fixed 0xFF/0x85 or derived from the last sample command.
    bit   stub_mode = 1'b0;
    int   stub_phase = 0;
    logic [7:0] stub_last = 8'h00;
    always @(posedge sys_clk) begin
        if (sys_rst) begin
            stub_phase <= 0;
            dec_rx     <= 8'h00;
        end else if (dec_rdy) begin
            if (dec_byte[0]) begin
                stub_last  <= dec_byte;
                stub_phase <= 1;
            end else if (dec_byte == 8'h80 && stub_phase == 1) begin
                dec_rx     <= stub_mode ? stub_last : 8'hFF;
                stub_phase <= 2;
            end else if (dec_byte == 8'h00 && stub_phase == 2) begin
                dec_rx     <= stub_mode ? (stub_last ^ 8'hA5) : 8'h85;
                stub_phase <= 3;
            end else if (dec_byte == 8'h00 && stub_phase == 3) begin
                stub_phase <= 0;
            end
        end
    end

    always @(negedge sys_clk) begin
        cyc++;
        if (sys_rst) begin
            prev_rdy  = 1'b0;
            mon_phase = 0;
        end else begin
            if (dec_rdy) begin
                n_cmp++;
                assert (prev_rdy === 1'b0) else begin
                    n_err++; $error("FAIL rdy_back_to_back obs=%b exp=0", prev_rdy);
                end
                n_cmp++;
                assert (exp_cmd_q.size() > 0) else begin
                    n_err++; $error("FAIL cmd_unexpected obs=%h exp=none", dec_byte);
                end
                if (exp_cmd_q.size() > 0) begin
                    e_cmd = exp_cmd_q.pop_front();
                    n_cmp++;
                    assert (dec_byte === e_cmd) else begin
                        n_err++; $error("FAIL cmd_byte obs=%h exp=%h", dec_byte, e_cmd);
                    end
                end
                if (dec_byte[0]) begin
                    mon_phase    = 1;
                    last_cmd_cyc = cyc;
                    n_scmd++;
                end else if (dec_byte == 8'h80 && mon_phase == 1) begin
                    mon_phase = 0;
                    n_cmp++;
                    assert ((cyc - last_cmd_cyc) == DL + 1) else begin
                        n_err++; $error("FAIL tx_spacing obs=%0d exp=%0d", cyc - last_cmd_cyc, DL + 1);
                    end
                end
            end
            if (out_valid && out_ready) begin
                n_pop++;
                n_cmp++;
                assert (exp_smp_q.size() > 0) else begin
                    n_err++; $error("FAIL sample_unexpected obs=%h exp=none", out_sample);
                end
                if (exp_smp_q.size() > 0) begin
                    e_smp = exp_smp_q.pop_front();
                    n_cmp++;
                    assert (out_sample === e_smp) else begin
                        n_err++; $error("FAIL sample obs=%h exp=%h", out_sample, e_smp);
                    end
                end
            end
            if (slice_done) n_done++;
            prev_rdy = dec_rdy;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++; $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic void push_slice(input logic [63:0] s, input bit mode);
        logic [7:0] c;
        logic [2:0] r;
        for (int i = 0; i < 20; i++) begin
            r = 3'((s >> (57 - 3 * i)) & 64'h7);
            c = {s[63:60], r, 1'b1};
            exp_cmd_q.push_back(c);
            exp_cmd_q.push_back(8'h80);
            exp_cmd_q.push_back(8'h00);
            exp_cmd_q.push_back(8'h00);
            exp_smp_q.push_back(mode ? {c, c ^ 8'hA5} : 16'hFF85);
        end
    endfunction

    task automatic send_byte(input logic [7:0] b, input logic l);
        in_data  = b;
        in_lms   = l;
        in_valid = 1'b1;
        for (int k = 0; k < 5000; k++) begin
            @(negedge sys_clk);
            if (in_ready) break;
        end
        check("byte_accept", {31'd0, in_ready}, 32'd1);
        @(posedge sys_clk);
        #1;
        in_valid = 1'b0;
        in_lms   = 1'b0;
    endtask

    task automatic send_slice(input logic [63:0] s);
        for (int i = 0; i < 8; i++) send_byte(s[63 - 8 * i -: 8], 1'b0);
    endtask

    task automatic wait_done(input int target, input int budget);
        for (int k = 0; k < budget && n_done < target; k++) @(posedge sys_clk);
        #2;
        check("slice_done_count", n_done, target);
    endtask

    task automatic check_idle();
        check("idle_in_ready", {31'd0, in_ready}, 32'd1);
        check("idle_dec_rdy", {31'd0, dec_rdy}, 32'd0);
        check("idle_dec_byte", {24'd0, dec_byte}, 32'd0);
        check("idle_out_valid", {31'd0, out_valid}, 32'd0);
        check("idle_out_sample", {16'd0, out_sample}, 32'd0);
        check("idle_busy", {31'd0, busy}, 32'd0);
        check("idle_slice_done", {31'd0, slice_done}, 32'd0);
    endtask

    logic [7:0] grp [16];
    int base;
    int pops0;

    initial begin
        sys_rst   = 1'b1;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        in_lms    = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge sys_clk);
        #1;
        check_idle();
        sys_rst = 1'b0;
        @(posedge sys_clk);
        #1;
        check_idle();

        // Slice decode with fixed 0xFF85 readback
        stub_mode = 1'b0;
        push_slice(64'h123456789ABCDEF0, 1'b0);
        send_slice(64'h123456789ABCDEF0);
        check("first_cmd_rdy", {31'd0, dec_rdy}, 32'd1);
        check("first_cmd_byte", {24'd0, dec_byte}, 32'h13);
        wait_done(1, 3000);
        repeat (4) @(posedge sys_clk);
        #1;
        check("s1_pops", n_pop, 20);
        check("s1_cmd_left", exp_cmd_q.size(), 0);
        check("s1_busy", {31'd0, busy}, 32'd0);

        // Backpressure: FIFO fills, then the block stalls in RESID
        stub_mode = 1'b1;
        out_ready = 1'b0;
        base = n_scmd;
        push_slice(64'hFEDCBA9876543210, 1'b1);
        send_slice(64'hFEDCBA9876543210);
        repeat (500) @(posedge sys_clk);
        #1;
        check("stall_cmds", n_scmd - base, FD);
        check("stall_out_valid", {31'd0, out_valid}, 32'd1);
        check("stall_head", {16'd0, out_sample}, {16'd0, exp_smp_q[0]});
        repeat (100) @(posedge sys_clk);
        #1;
        check("stall_cmds_hold", n_scmd - base, FD);
        check("stall_dec_rdy", {31'd0, dec_rdy}, 32'd0);
        check("stall_busy", {31'd0, busy}, 32'd1);
        out_ready = 1'b1;
        wait_done(2, 3000);
        repeat (4) @(posedge sys_clk);
        #1;
        check("s2_pops", n_pop, 40);
        check("s2_smp_left", exp_smp_q.size(), 0);

        // Reset during WAIT of residual 7
        base = n_scmd;
        push_slice(64'h0F1E2D3C4B5A6978, 1'b1);
        send_slice(64'h0F1E2D3C4B5A6978);
        for (int k = 0; k < 3000 && (n_scmd - base) < 8; k++) @(posedge sys_clk);
        #1;
        check("resid7_reached", n_scmd - base, 8);
        repeat (10) @(posedge sys_clk);
        #1;
        sys_rst = 1'b1;
        exp_cmd_q.delete();
        exp_smp_q.delete();
        @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
        check_idle();
        check("rst_done_cnt", n_done, 2);
        pops0 = n_pop;
        push_slice(64'hA5C3F00F5A3C0FF0, 1'b1);
        send_slice(64'hA5C3F00F5A3C0FF0);
        wait_done(3, 3000);
        repeat (4) @(posedge sys_clk);
        #1;
        check("s3_pops", n_pop - pops0, 20);
        check("s3_cmd_left", exp_cmd_q.size(), 0);

        // 16-byte LMS-tagged group
        for (int i = 0; i < 16; i++) grp[i] = 8'h00;
        grp[0]  = 8'h12;
        grp[1]  = 8'h34;
        grp[14] = 8'hBE;
        grp[15] = 8'hEF;
        pops0 = n_pop;
`ifdef QOA_LMS_LOAD_EN
        for (int k = 0; k < 8; k++) begin
            exp_cmd_q.push_back({4'b0000, 2'(k & 3), 1'((k >> 2) & 1), 1'b0});
            exp_cmd_q.push_back(grp[2 * k]);
            exp_cmd_q.push_back(grp[2 * k + 1]);
        end
        for (int i = 0; i < 16; i++) send_byte(grp[i], (i == 0) ? 1'b1 : 1'b0);
        for (int k = 0; k < 200 && (busy || exp_cmd_q.size() != 0); k++) @(posedge sys_clk);
        #1;
        check("lms_busy", {31'd0, busy}, 32'd0);
        check("lms_cmd_left", exp_cmd_q.size(), 0);
        check("lms_no_done", n_done, 3);
        check("lms_no_pops", n_pop - pops0, 0);
`else
        push_slice({grp[0], grp[1], grp[2], grp[3], grp[4], grp[5], grp[6], grp[7]}, 1'b1);
        push_slice({grp[8], grp[9], grp[10], grp[11], grp[12], grp[13], grp[14], grp[15]}, 1'b1);
        for (int i = 0; i < 16; i++) send_byte(grp[i], (i == 0) ? 1'b1 : 1'b0);
        wait_done(5, 3000);
        repeat (4) @(posedge sys_clk);
        #1;
        check("lms_off_pops", n_pop - pops0, 40);
        check("lms_off_cmd_left", exp_cmd_q.size(), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
